// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the sizing helper for the bit counter.
package serial_add_pkg;

    // Default operand width when the parent does not override it.
    localparam int WIDTH_DEFAULT = 8;

    // Controller states. Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } st_e;

    // Width of the bit counter. The counter indexes 0..w-1, so $clog2(w)
    // bits are enough. The result is clamped to 1 so that w<2 still gives a
    // legal vector.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between the operand source (master) and the
// bit-serial adder controller (slave).
//
// Handshake: start/done. The master raises start with a, b and cin valid.
// The controller accepts on a rising edge only while it is in ST_IDLE; a, b
// and cin matter only on that edge. A start in any other state is dropped,
// not queued. done is a one-cycle pulse. It marks the first cycle in which
// sum and cout hold the new result, and those values stay until the next
// result. busy is high while bits are being processed. busy and done are
// never high together. state is a read-only view of the controller FSM.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                      start;
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic                      cin;
    logic                      busy;
    logic                      done;
    logic [WIDTH-1:0]          sum;
    logic                      cout;
    serial_add_pkg::st_e       state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, state
    );
endinterface : serial_add_ctrl_if

// File: rtl/full_adder.sv
// Single-bit full adder cell: the only arithmetic in the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic w_p;

    // Propagate term, shared by the sum and the carry.
    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);
endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller. One full_adder cell is time-shared
// across the operand bits, LSB first, at one bit per clock. Results are
// published in output registers that change only when a run completes.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Controller state and status.
    st_e              r_state;
    logic             r_busy;
    logic             r_done;

    // Serial datapath registers.
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ps;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    // Published result.
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Adder cell outputs and the partial sum after this bit has shifted in.
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_ps_next;

    full_adder u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_c),
        .sum  (w_s),
        .cout (w_co)
    );

    // The new bit enters at the MSB. After WIDTH shifts the first bit has
    // reached bit 0, so on the last edge this vector is already the full sum.
    assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};

    // FSM, serial datapath and output registers. busy and done are
    // registered, so they have no combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_ps    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_c     <= bus.cin;
                        r_ps    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_ps  <= w_ps_next;
                    r_c   <= w_co;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_ps_next;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // done lasts exactly one cycle. start is not sampled here.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    // Unused encoding: return to a known idle state.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;
    assign bus.state = r_state;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8). Stimulus pushes the expected
// {cout,sum} into exp_q. A monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int n_pushed  = 0;
    int cyc       = 0;
    bit b2b       = 1'b0;
    int last_done_cyc = -1;

    logic [W:0] exp_q[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        logic [W:0] e;
        if (!b2b) last_done_cyc = -1;
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            check("busy_done_excl", {31'd0, bus.busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=0x%0h expected=none", {bus.cout, bus.sum});
            end else begin
                e = exp_q.pop_front();
                check("result", {23'd0, bus.cout, bus.sum}, {23'd0, e});
            end
            if (b2b && last_done_cyc >= 0)
                check("b2b_done_gap", cyc - last_done_cyc, 10);
            last_done_cyc = cyc;
        end
    end

    // Waits, bounded, until the controller reports IDLE. Returns at a negedge.
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.state !== ST_IDLE && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.state !== ST_IDLE) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout actual=%0d expected=%0d", bus.state, ST_IDLE);
        end
    endtask

    // Issues one operation. Returns at the negedge after the accepting edge
    // with start already low.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] exp, input bit push);
        wait_idle(40);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            n_pushed++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits, bounded, for the next done pulse seen by the monitor.
    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) begin
            checks++;
            failures++;
            $display("FAIL wait_done_timeout actual=%0d expected=%0d", done_cnt, base + 1);
        end
    endtask

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL global_timeout actual=%0d expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int done_at;
        int dc_before;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rexp;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {24'd0, bus.sum}, 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        rst = 1'b0;

        // 1: zero operands, latency and busy length.
        issue(8'h00, 8'h00, 1'b0, 9'h000, 1'b1);
        busy_cycles = 0;
        done_at     = 0;
        for (int k = 1; k <= 14; k++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1 && done_at == 0) done_at = k;
            @(negedge clk);
        end
        check("busy_cycles", busy_cycles, 8);
        check("done_latency", done_at, 9);

        // 2: plain add and wrap-around.
        issue(8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b1);
        wait_done(30);
        issue(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        wait_done(30);

        // 3: carry ripples through every bit.
        issue(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
        wait_done(30);

        // 4: start during RUN is ignored; operands change mid-run.
        dc_before = done_cnt;
        issue(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
        repeat (2) @(negedge clk);
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(30);
        repeat (15) @(negedge clk);
        check("no_second_done", done_cnt, dc_before + 1);
        check("hold_sum", {24'd0, bus.sum}, 32'h02);

        // 5: reset in the 4th RUN cycle aborts without done.
        dc_before = done_cnt;
        issue(8'h0F, 8'h0F, 1'b0, 9'h000, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_sum", {24'd0, bus.sum}, 32'd0);
        check("abort_cout", {31'd0, bus.cout}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt, dc_before);
        issue(8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
        wait_done(30);

        // 6: back-to-back sweep with start held high.
        wait_idle(40);
        b2b = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom_range(0, 255));
            rb   = W'($urandom_range(0, 255));
            rc   = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            bus.a     = ra;
            bus.b     = rb;
            bus.cin   = rc;
            bus.start = 1'b1;
            exp_q.push_back(rexp);
            n_pushed++;
            @(posedge clk);
            @(negedge clk);
            if (i == 999) bus.start = 1'b0;
            repeat (9) @(posedge clk);
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        b2b = 1'b0;

        check("queue_drained", exp_q.size(), 0);
        check("done_total", done_cnt, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_ctrl
